plic_claim_ctrl: RTL and testbench
==================================

Name: plic_claim_ctrl

Overview:
- Per-target claim/complete controller for the PLIC source-target matrix.
- Consumes the registered id/priority pair from every cell in one target column and selects the highest-priority pending source.
- Compares that winner against the target threshold to drive the target interrupt line.
- Sequences the claim-read and complete-write handshakes, tracking in-service sources so a claimed source is masked until completed.

Parameters:
SOURCES, 8, number of interrupt sources (IDs 1..SOURCES; ID 0 = none)
PRIORITIES, 7, number of priority levels (0 = never interrupts)
SOURCES_BITS, 4, ID width; must be >= clog2(SOURCES+1)
PRIORITY_BITS, 3, priority width; must be >= clog2(PRIORITIES+1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
id_i  in  SOURCES*SOURCES_BITS  per-cell pending ID, lane k = source k+1; 0 when not pending/enabled
priority_i  in  SOURCES*PRIORITY_BITS  per-cell pending priority, lane k; 0 when not pending/enabled
threshold_i  in  PRIORITY_BITS  target priority threshold
claim_req_i  in  1  claim-register read strobe
claim_ack_o  out  1  claim response valid, one-cycle pulse
claim_id_o  out  SOURCES_BITS  claimed ID, valid with claim_ack_o; 0 = nothing to claim
claim_o  out  SOURCES  one-hot pulse to gateway, bit id-1; clears source pending
complete_i  in  1  complete-register write strobe
complete_id_i  in  SOURCES_BITS  ID being completed
complete_o  out  SOURCES  one-hot pulse to gateway, bit id-1; re-arms source
irq_o  out  1  target interrupt request
in_service_o  out  SOURCES  in-service mask, bit id-1

Behaviour:
- Reset: all outputs 0, in_service 0, best_id_q/best_pri_q 0, FSM IDLE. Asserting rst_i mid-handshake aborts it: no ack, no claim_o.
- Selection stage, registered every cycle:
  - Candidate lane k requires id_i[k]!=0 and in_service[k]==0.
  - best = maximum priority_i among candidates; ties go to the lowest ID.
  - No candidate, or max priority 0: best_id_q=0, best_pri_q=0.
- irq_o is registered in the same stage as the selection: 1 iff best_pri > threshold_i (strict). threshold_i >= PRIORITIES masks all sources. Latency: cell output change to irq_o is 1 cycle.
- Claim FSM has two states, IDLE and ACK:
  - IDLE, claim_req_i=1 at edge E0:
    - Capture claim_id = (best_pri_q > threshold_i) ? best_id_q : 0.
    - If claim_id!=0, set in_service[claim_id-1] at E0.
    - Go to ACK.
  - ACK lasts exactly one cycle:
    - claim_ack_o=1 and claim_id_o=captured ID.
    - claim_o[claim_id-1]=1 if claim_id!=0.
    - Return to IDLE at E1.
  - claim_req_i while in ACK is ignored; the requester holds or re-issues it.
  - claim_id_o holds its value until the next capture. claim_ack_o and claim_o are otherwise 0.
  - Back-to-back claims never return the same ID: the selection registered at E1 already excludes the new in-service bit.
- Complete, sampled every cycle in any FSM state:
  - Applies when complete_i=1, 1<=complete_id_i<=SOURCES and in_service[complete_id_i-1]=1.
  - On that edge, clear the bit; complete_o[complete_id_i-1] pulses for the following cycle.
  - Any other ID (0, >SOURCES, not in service) is ignored silently: no pulse, no state change.
- A claim capture and a complete in the same edge always act on disjoint sources, because a claim never selects an in-service source. Both take effect.
- A completed source becomes selectable in the selection registered one edge after in_service clears.
- Widths: all comparisons are unsigned at PRIORITY_BITS. IDs are compared at SOURCES_BITS, with no truncation permitted.

Test Plan:
- Sources 3 (pri 5) and 6 (pri 2) pending, threshold 1 → irq_o=1 one cycle later. claim_req_i → next cycle claim_ack_o=1, claim_id_o=3, claim_o=8'b0000_0100, in_service_o bit2 set.
- Sources 2 and 5 both pri 4, threshold 0 → claim returns 2. Second claim issued right after the ack → returns 5. Third claim → claim_id_o=0, no claim_o.
- Source 4 pri 3 with threshold 3 → irq_o=0, claim returns 0. Lower threshold to 2 → irq_o=1 after 1 cycle, claim returns 4.
- Claim source 1 then complete_id_i=1 → complete_o=8'b0000_0001 next cycle, in_service cleared. complete_id_i=7 (not in service) and complete_id_i=0 → no pulse.
- Same-edge claim of source 6 and complete of previously claimed source 2 → in_service bit5 set and bit1 cleared together. Both pulses appear next cycle.
- Assert rst_i during ACK → claim_ack_o, claim_o, irq_o and in_service_o go to 0 immediately. After release the FSM is IDLE and a fresh claim works.

Source files
------------

// File: rtl/plic_claim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : plic_claim_ctrl
// Brief    : PLIC per-target claim/complete controller with in-service masking
//            and a registered highest-priority selection stage.
// Revision : 1.0
// ============================================================================
module plic_claim_ctrl #(
    parameter int SOURCES       = 8,
    parameter int PRIORITIES    = 7,
    parameter int SOURCES_BITS  = 4,
    parameter int PRIORITY_BITS = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [SOURCES*SOURCES_BITS-1:0]    id_i,
    input  logic [SOURCES*PRIORITY_BITS-1:0]   priority_i,
    input  logic [PRIORITY_BITS-1:0]           threshold_i,
    input  logic                               claim_req_i,
    output logic                               claim_ack_o,
    output logic [SOURCES_BITS-1:0]            claim_id_o,
    output logic [SOURCES-1:0]                 claim_o,
    input  logic                               complete_i,
    input  logic [SOURCES_BITS-1:0]            complete_id_i,
    output logic [SOURCES-1:0]                 complete_o,
    output logic                               irq_o,
    output logic [SOURCES-1:0]                 in_service_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam logic [PRIORITY_BITS-1:0] C_MAX_PRI = PRIORITY_BITS'(PRIORITIES);

    state_t                     r_state;
    logic [SOURCES_BITS-1:0]    r_best_id;
    logic [PRIORITY_BITS-1:0]   r_best_pri;
    logic                       r_irq;
    logic                       r_claim_ack;
    logic [SOURCES_BITS-1:0]    r_claim_id;
    logic [SOURCES-1:0]         r_claim;
    logic [SOURCES-1:0]         r_complete;
    logic [SOURCES-1:0]         r_in_service;

    logic [SOURCES_BITS-1:0]    w_best_id;
    logic [PRIORITY_BITS-1:0]   w_best_pri;
    logic                       w_masked;
    logic [SOURCES_BITS-1:0]    w_cap_id;
    logic [SOURCES-1:0]         w_claim_oh;
    logic [SOURCES-1:0]         w_comp_oh;
    logic [SOURCES-1:0]         w_set;
    logic [SOURCES-1:0]         w_clr;

    // Ascending scan with strict compare keeps the lowest ID on priority ties.
    always_comb begin
        w_best_id  = '0;
        w_best_pri = '0;
        for (int k = 0; k < SOURCES; k++) begin
            if ((id_i[k*SOURCES_BITS +: SOURCES_BITS] != '0) && !r_in_service[k] &&
                (priority_i[k*PRIORITY_BITS +: PRIORITY_BITS] > w_best_pri)) begin
                w_best_pri = priority_i[k*PRIORITY_BITS +: PRIORITY_BITS];
                w_best_id  = SOURCES_BITS'(k + 1);
            end
        end
    end

    assign w_masked = (threshold_i >= C_MAX_PRI);
    assign w_cap_id = (!w_masked && (r_best_pri > threshold_i)) ? r_best_id : '0;

    // ID 0 and IDs above SOURCES decode to an empty mask.
    always_comb begin
        w_claim_oh = '0;
        w_comp_oh  = '0;
        for (int k = 0; k < SOURCES; k++) begin
            w_claim_oh[k] = (w_cap_id == SOURCES_BITS'(k + 1));
            w_comp_oh[k]  = (complete_id_i == SOURCES_BITS'(k + 1));
        end
    end

    assign w_set = ((r_state == ST_IDLE) && claim_req_i) ? w_claim_oh : '0;
    assign w_clr = complete_i ? (w_comp_oh & r_in_service) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_best_id    <= '0;
            r_best_pri   <= '0;
            r_irq        <= 1'b0;
            r_claim_ack  <= 1'b0;
            r_claim_id   <= '0;
            r_claim      <= '0;
            r_complete   <= '0;
            r_in_service <= '0;
        end else begin
            r_best_id    <= w_best_id;
            r_best_pri   <= w_best_pri;
            r_irq        <= !w_masked && (w_best_pri > threshold_i);
            r_in_service <= (r_in_service | w_set) & ~w_clr;
            r_complete   <= w_clr;
            case (r_state)
                ST_IDLE: begin
                    r_claim_ack <= 1'b0;
                    r_claim     <= '0;
                    if (claim_req_i) begin
                        r_state     <= ST_ACK;
                        r_claim_ack <= 1'b1;
                        r_claim_id  <= w_cap_id;
                        r_claim     <= w_claim_oh;
                    end
                end
                ST_ACK: begin
                    r_state     <= ST_IDLE;
                    r_claim_ack <= 1'b0;
                    r_claim     <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_claim_ack <= 1'b0;
                    r_claim     <= '0;
                end
            endcase
        end
    end

    assign claim_ack_o  = r_claim_ack;
    assign claim_id_o   = r_claim_id;
    assign claim_o      = r_claim;
    assign complete_o   = r_complete;
    assign irq_o        = r_irq;
    assign in_service_o = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_plic_claim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_claim_ctrl
// Brief    : Directed self-checking bench for plic_claim_ctrl against a
//            per-source behavioural model.
// Revision : 1.0
// ============================================================================
module tb_plic_claim_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] id_v;
    logic [23:0] pri_v;
    logic [2:0]  thr;
    logic        creq;
    logic        cmp;
    logic [3:0]  cmp_id;
    logic        claim_ack;
    logic [3:0]  claim_id;
    logic [7:0]  claim_oh;
    logic [7:0]  complete_oh;
    logic        irq;
    logic [7:0]  in_service;

    int src_pri [1:8];
    int n_tests = 0;
    int n_fail  = 0;

    plic_claim_ctrl #(
        .SOURCES       (8),
        .PRIORITIES    (7),
        .SOURCES_BITS  (4),
        .PRIORITY_BITS (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_i          (id_v),
        .priority_i    (pri_v),
        .threshold_i   (thr),
        .claim_req_i   (creq),
        .claim_ack_o   (claim_ack),
        .claim_id_o    (claim_id),
        .claim_o       (claim_oh),
        .complete_i    (cmp),
        .complete_id_i (cmp_id),
        .complete_o    (complete_oh),
        .irq_o         (irq),
        .in_service_o  (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A source with non-zero priority is presented as pending by its cell.
    always_comb begin
        id_v  = '0;
        pri_v = '0;
        for (int k = 0; k < 8; k++) begin
            if (src_pri[k+1] != 0) id_v[k*4 +: 4] = 4'(k + 1);
            pri_v[k*3 +: 3] = 3'(src_pri[k+1]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model, per source ID
    bit [8:1] m_busy, m_claim, m_comp;
    int       m_best, m_bpri, m_cid;
    bit       m_irq, m_in_ack, m_ack;

    always @(posedge clk or posedge rst) begin
        int w, wp, cid, cc;
        bit cap, cv;
        bit [8:1] nb;
        if (rst) begin
            m_busy = '0; m_claim = '0; m_comp = '0;
            m_best = 0; m_bpri = 0; m_cid = 0;
            m_irq = 0; m_in_ack = 0; m_ack = 0;
        end else begin
            w = 0; wp = 0;
            for (int id = 1; id <= 8; id++)
                if (!m_busy[id] && src_pri[id] > wp) begin w = id; wp = src_pri[id]; end
            cap = !m_in_ack && creq;
            cid = (m_bpri > int'(thr)) ? m_best : 0;
            cc  = int'(cmp_id);
            cv  = cmp && (cc >= 1) && (cc <= 8) && m_busy[cc];
            nb  = m_busy;
            if (cap && cid != 0) nb[cid] = 1'b1;
            if (cv) nb[cc] = 1'b0;
            m_comp  = '0; if (cv) m_comp[cc] = 1'b1;
            m_claim = '0; if (cap && cid != 0) m_claim[cid] = 1'b1;
            m_ack    = cap;
            if (cap) m_cid = cid;
            m_in_ack = cap;
            m_busy   = nb;
            m_best   = w;
            m_bpri   = wp;
            m_irq    = wp > int'(thr);
        end
    end

    always @(negedge clk) begin
        chk("ack",        {31'd0, claim_ack},   {31'd0, m_ack});
        chk("claim_id",   {28'd0, claim_id},    m_cid);
        chk("claim_o",    {24'd0, claim_oh},    {24'd0, m_claim});
        chk("complete_o", {24'd0, complete_oh}, {24'd0, m_comp});
        chk("irq",        {31'd0, irq},         {31'd0, m_irq});
        chk("in_service", {24'd0, in_service},  {24'd0, m_busy});
    end

    task automatic do_claim(input int exp_id);
        bit got;
        got  = 1'b0;
        creq = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (claim_ack) got = 1'b1;
        end
        creq = 1'b0;
        chk("claim_ack_seen", {31'd0, got}, 32'd1);
        chk("claim_id_lit", {28'd0, claim_id}, exp_id);
    endtask

    task automatic do_complete(input int id, input logic [7:0] exp_pulse);
        cmp    = 1'b1;
        cmp_id = 4'(id);
        @(negedge clk);
        cmp    = 1'b0;
        cmp_id = '0;
        chk("complete_lit", {24'd0, complete_oh}, {24'd0, exp_pulse});
    endtask

    initial begin
        rst = 1'b1; creq = 1'b0; cmp = 1'b0; cmp_id = '0; thr = '0;
        for (int i = 1; i <= 8; i++) src_pri[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_in_service", {24'd0, in_service}, 32'd0);
        chk("rst_claim_id", {28'd0, claim_id}, 32'd0);
        rst = 1'b0;

        // Highest priority wins; irq one cycle after cells change
        thr = 3'd1; src_pri[3] = 5; src_pri[6] = 2;
        @(negedge clk);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        do_claim(3);
        chk("t1_claim_o", {24'd0, claim_oh}, 32'h04);
        chk("t1_in_service", {24'd0, in_service}, 32'h04);
        src_pri[3] = 0; src_pri[6] = 0;
        do_complete(3, 8'h04);

        // Tie goes to lowest ID; back-to-back claims never repeat
        thr = 3'd0; src_pri[2] = 4; src_pri[5] = 4;
        @(negedge clk);
        do_claim(2);
        do_claim(5);
        do_claim(0);
        chk("t2_claim_o", {24'd0, claim_oh}, 32'h00);
        chk("t2_in_service", {24'd0, in_service}, 32'h12);
        src_pri[2] = 0; src_pri[5] = 0;
        do_complete(2, 8'h02);
        do_complete(5, 8'h10);

        // Threshold is strict
        thr = 3'd3; src_pri[4] = 3;
        @(negedge clk);
        chk("t3_irq_masked", {31'd0, irq}, 32'd0);
        do_claim(0);
        thr = 3'd2;
        @(negedge clk);
        chk("t3_irq", {31'd0, irq}, 32'd1);
        do_claim(4);
        src_pri[4] = 0;
        do_complete(4, 8'h08);

        // Completes of unclaimed or out-of-range IDs are ignored
        thr = 3'd0; src_pri[1] = 6;
        @(negedge clk);
        do_claim(1);
        src_pri[1] = 0;
        do_complete(1, 8'h01);
        chk("t4_in_service", {24'd0, in_service}, 32'h00);
        do_complete(7, 8'h00);
        do_complete(0, 8'h00);
        do_complete(9, 8'h00);

        // Same-edge claim and complete on different sources
        src_pri[2] = 5;
        @(negedge clk);
        do_claim(2);
        src_pri[2] = 0; src_pri[6] = 3;
        @(negedge clk);
        creq = 1'b1; cmp = 1'b1; cmp_id = 4'd2;
        @(negedge clk);
        creq = 1'b0; cmp = 1'b0; cmp_id = '0;
        chk("t5_ack", {31'd0, claim_ack}, 32'd1);
        chk("t5_claim_id", {28'd0, claim_id}, 32'd6);
        chk("t5_claim_o", {24'd0, claim_oh}, 32'h20);
        chk("t5_complete_o", {24'd0, complete_oh}, 32'h02);
        chk("t5_in_service", {24'd0, in_service}, 32'h20);
        src_pri[6] = 0;
        do_complete(6, 8'h20);

        // Reset during ACK aborts the handshake immediately
        src_pri[7] = 4;
        @(negedge clk);
        creq = 1'b1;
        @(negedge clk);
        creq = 1'b0;
        chk("t6_pre_ack", {31'd0, claim_ack}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ack", {31'd0, claim_ack}, 32'd0);
        chk("t6_rst_claim_o", {24'd0, claim_oh}, 32'h00);
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        chk("t6_rst_in_service", {24'd0, in_service}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_claim(7);
        chk("t6_claim_o", {24'd0, claim_oh}, 32'h40);
        src_pri[7] = 0;
        do_complete(7, 8'h40);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
